// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce, press/release/long-press pulses, press counter.
// "release" is a reserved word, so the falling-edge pulse port is named release_pulse.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int LONG_CYCLES     = 24000000,
   parameter int COUNT_W         = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               button,
   output logic               btn_level,
   output logic               press,
   output logic               release_pulse,
   output logic               long_press,
   output logic [COUNT_W-1:0] press_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   logic          sync_1;
   logic          sync_2;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   logic          flip;
   logic          rise;
   logic          fall;

   always_comb begin
      flip = 1'b0;
      rise = 1'b0;
      fall = 1'b0;
      if ((sync_2 != btn_level) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1))) begin
         flip = 1'b1;
         rise = sync_2;
         fall = ~sync_2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= button;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cnt   <= '0;
         btn_level <= 1'b0;
      end else if (sync_2 == btn_level) begin
         deb_cnt <= '0;
      end else if (flip) begin
         btn_level <= sync_2;
         deb_cnt   <= '0;
      end else begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press         <= 1'b0;
         release_pulse <= 1'b0;
         press_count   <= '0;
      end else begin
         press         <= rise;
         release_pulse <= fall;
         if (rise) begin
            press_count <= press_count + COUNT_W'(1);
         end
      end
   end

   // Hold counter clears on the falling edge itself, so long_press can never coincide with release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt   <= '0;
         long_press <= 1'b0;
      end else begin
         if (!btn_level || fall) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HW'(LONG_CYCLES)) begin
            hold_cnt <= hold_cnt + HW'(1);
         end
         long_press <= btn_level && !fall && (hold_cnt == HW'(LONG_CYCLES - 1));
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: window-based behavioural model checked every cycle, plus directed scenarios.
module tb_button_conditioner;
   localparam int D  = 4;
   localparam int L  = 20;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          button;
   logic          btn_level;
   logic          press;
   logic          rel;
   logic          long_press;
   logic [CW-1:0] press_count;

   int errors = 0;
   int checks = 0;
   int long_seen = 0;

   button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .COUNT_W(CW)) dut (
      .clk(clk), .rst(rst), .button(button), .btn_level(btn_level), .press(press),
      .release_pulse(rel), .long_press(long_press), .press_count(press_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: the level flips once the last D synchronised samples all disagree with it.
   logic m_s1, m_s2, m_lvl, m_press, m_rel, m_long;
   int   m_cnt, age;
   logic win[$];

   always begin
      logic b, r, all_diff;
      @(posedge clk);
      b = button;
      r = rst;
      #1;
      if (r) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_long = 0;
         m_cnt = 0; age = 0; win.delete();
      end else begin
         m_press = 0; m_rel = 0; m_long = 0;
         win.push_back(m_s2);
         if (win.size() > D) void'(win.pop_front());
         all_diff = (win.size() == D);
         foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
         if (all_diff) begin
            m_lvl = ~m_lvl;
            win.delete();
            if (m_lvl) begin
               m_press = 1;
               m_cnt = (m_cnt + 1) % (1 << CW);
               age = 0;
            end else begin
               m_rel = 1;
            end
         end else if (m_lvl) begin
            age++;
            if (age == L) m_long = 1;
         end
         m_s2 = m_s1;
         m_s1 = b;
      end
      chk("level", {31'd0, btn_level}, {31'd0, m_lvl});
      chk("press", {31'd0, press}, {31'd0, m_press});
      chk("release", {31'd0, rel}, {31'd0, m_rel});
      chk("long_press", {31'd0, long_press}, {31'd0, m_long});
      chk("press_count", {30'd0, press_count}, m_cnt);
      if (long_press === 1'b1) long_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic sel(input int which);
      case (which)
         0:       return press;
         1:       return rel;
         default: return long_press;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sel(which) !== 1'b1 && n < limit);
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      repeat (2) tick();
   endtask

   initial begin
      int n, l0;
      int wrap_exp[5] = '{1, 2, 3, 0, 1};
      rst = 1;
      button = 0;
      #1;
      chk("reset_level", {31'd0, btn_level}, 0);
      chk("reset_count", {30'd0, press_count}, 0);
      do_reset();

      // Clean press: level and press appear 6 edges after the input changes
      button = 1;
      repeat (5) tick();
      chk("pre_level", {31'd0, btn_level}, 0);
      tick();
      chk("clean_level", {31'd0, btn_level}, 1);
      chk("clean_press", {31'd0, press}, 1);
      chk("clean_count", {30'd0, press_count}, 1);
      tick();
      chk("clean_press_drop", {31'd0, press}, 0);
      button = 0;
      wait_sig(1, 20, n);
      chk("clean_release_lat", n, 6);
      repeat (4) tick();

      // Bounce: no excursion reaches D samples
      button = 1; repeat (3) tick();
      button = 0; tick();
      button = 1; repeat (2) tick();
      button = 0; repeat (10) tick();
      chk("bounce_level", {31'd0, btn_level}, 0);
      chk("bounce_count", {30'd0, press_count}, 1);

      // Long hold of 40 cycles
      l0 = long_seen;
      button = 1;
      wait_sig(0, 20, n);
      chk("long_press_lat", n, 6);
      wait_sig(2, 40, n);
      chk("long_after_press", n, 20);
      repeat (40 - 26) tick();
      button = 0;
      wait_sig(1, 20, n);
      chk("long_release_lat", n, 6);
      repeat (10) tick();
      chk("long_once", long_seen - l0, 1);
      chk("long_count", {30'd0, press_count}, 2);

      // Short hold of 10 cycles
      l0 = long_seen;
      button = 1;
      repeat (10) tick();
      button = 0;
      wait_sig(1, 20, n);
      chk("short_release_lat", n, 6);
      repeat (25) tick();
      chk("short_no_long", long_seen - l0, 0);
      chk("short_count", {30'd0, press_count}, 3);

      // Counter wrap from a fresh reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         button = 1; repeat (8) tick();
         button = 0; repeat (8) tick();
         chk("wrap_count", {30'd0, press_count}, wrap_exp[i]);
      end

      // Asynchronous reset mid-hold, then restart with the button still held
      button = 1;
      wait_sig(0, 20, n);
      repeat (3) tick();
      #1 rst = 1;
      #1;
      chk("async_level", {31'd0, btn_level}, 0);
      chk("async_count", {30'd0, press_count}, 0);
      chk("async_pulses", {29'd0, press, rel, long_press}, 0);
      tick();
      rst = 0;
      wait_sig(0, 20, n);
      chk("rst_held_press_lat", n, 6);
      wait_sig(2, 40, n);
      chk("rst_held_long_lat", n, 20);
      button = 0;
      repeat (10) tick();

      // Randomised runs with occasional mid-cycle resets
      for (int i = 0; i < 400; i++) begin
         int len;
         button = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 7);
         repeat (len) tick();
         if ($urandom_range(0, 40) == 0) begin
            #1 rst = 1;
            #1;
            chk("rand_async_level", {31'd0, btn_level}, 0);
            tick();
            rst = 0;
         end
      end
      button = 0;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side companion to the board clock/LED test logic: turns a raw, bouncy, asynchronous push-button into clean, clk-synchronous events.
- Output events: debounced level, one-cycle press and release pulses, a one-shot long-press pulse, and a wrapping press counter.
- Sits between the board button pin and any consumer (LED test logic, mode selection).
- Timing parameters are in clock cycles, so benches can use small values while the board build uses ms-scale counts at 24 MHz.

Parameters:
- DEBOUNCE_CYCLES, 240000, consecutive cycles the synchronised input must differ from the debounced level before the level changes; must be >= 1.
- LONG_CYCLES, 24000000, cycles the debounced level must stay high before long_press fires; must be >= 1.
- COUNT_W, 8, width of press_count.

Ports:
- clk  input  1  system clock (24 MHz on board).
- rst  input  1  asynchronous, active-high reset.
- button  input  1  raw button pin, asynchronous to clk, active-high.
- btn_level  output  1  debounced button level.
- press  output  1  one-cycle pulse on debounced rising edge.
- release  output  1  one-cycle pulse on debounced falling edge.
- long_press  output  1  one-cycle pulse once per hold reaching LONG_CYCLES.
- press_count  output  COUNT_W  number of debounced presses, modulo 2^COUNT_W.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - sync_1, sync_2, btn_level, press, release, long_press = 0.
  - press_count = 0.
  - debounce counter and hold counter = 0.
- Synchroniser: two flops, sync_1 <= button, sync_2 <= sync_1. Only sync_2 feeds the debounce logic.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)):
  - If sync_2 == btn_level: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: btn_level <= sync_2 and counter <= 0.
  - Otherwise: counter increments.
- Latency: button is first sampled high at edge k and held. sync_2 is high after edge k+1; btn_level goes high at edge k+1+DEBOUNCE_CYCLES. The same rule applies to release.
- Glitch rejection: any excursion of sync_2 shorter than DEBOUNCE_CYCLES clears the counter and leaves btn_level unchanged.
- press, release, press_count:
  - press is registered and high for exactly the one cycle following the edge where btn_level goes 0->1.
  - release behaves the same on 1->0.
  - press and release are never high together.
  - press_count increments on the same edge press is asserted, and wraps from 2^COUNT_W-1 to 0.
- Hold counter (width $clog2(LONG_CYCLES+1), saturating at LONG_CYCLES):
  - Cleared whenever btn_level is 0.
  - Increments every cycle btn_level is 1.
  - long_press is high for one cycle on the edge the counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after press asserts.
  - Saturation guarantees at most one long_press per hold.
  - A release before saturation produces no long_press.
  - After a long press, release still pulses normally.
- Simultaneous events: long_press and release cannot coincide, because the hold counter clears as btn_level falls. With LONG_CYCLES=1, long_press fires the cycle after press.
- Button held through reset: btn_level restarts at 0, so a press is reported DEBOUNCE_CYCLES+2 edges after reset deasserts. This is intentional.
- Reset mid-hold or mid-debounce: all state is lost immediately, and no pulse is emitted for the interrupted event.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, COUNT_W=2, clk period 10):
- Clean press: button 0->1 before edge 10, held -> btn_level=1 and press=1 after edge 15; press=0 after edge 16; press_count=1.
- Bounce: button high 3 cycles, low 1, high 2, low -> btn_level stays 0; press, release, press_count unchanged.
- Long hold: button held 40 cycles -> long_press exactly once, 20 cycles after press; release one pulse 6 cycles after button falls; no second long_press.
- Short hold: button held 10 cycles -> press then release pulses; long_press never asserted.
- Counter wrap: 5 clean presses -> press_count sequence 1,2,3,0,1.
- Async reset: assert rst mid-hold between edges (after press, before long_press) -> all outputs 0 immediately, without waiting for clk. Then deassert rst with button still high -> press 6 edges later; long_press 20 cycles after that.
